float_point_add_sub: RTL and testbench



---
 rtl/float_point_add_sub_pkg.sv | 21 ++
 rtl/float_point_add_sub_leading_zero_counter.sv | 23 ++
 rtl/float_point_add_sub.sv | 246 ++++++++++++++++++++++++
 tb/tb_float_point_add_sub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_point_add_sub_pkg.sv
// Shared definitions for the floating-point add/sub unit: default widths,
// FSM state encodings, round-mode and operation codes.
package float_point_add_sub_pkg;

  localparam int DOUBLE_POINT_NUMBER_EXPONENT_WIDTH_IN_BITS = 11;
  localparam int DOUBLE_POINT_NUMBER_FRACTION_WIDTH_IN_BITS = 52;

  typedef enum logic [2:0] {
    STATE_IDLE      = 3'd0,
    STATE_ALIGN     = 3'd1,
    STATE_ADD       = 3'd2,
    STATE_NORMALIZE = 3'd3,
    STATE_ROUND     = 3'd4,
    STATE_HOLD      = 3'd5
  } state_t;

  localparam logic ROUND_MODE_CHOP = 1'b0;
  localparam logic ROUND_MODE_RNE  = 1'b1;
  localparam logic OPERATION_SUB   = 1'b1;

endpackage

// File: rtl/float_point_add_sub_leading_zero_counter.sv
// Combinational leading-zero count; an all-zero input reports WIDTH.
module leading_zero_counter #(
  parameter int WIDTH       = 56,
  parameter int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]       value_in,
  output logic [COUNT_WIDTH-1:0] count_out
);

  logic found;

  always_comb begin
    count_out = COUNT_WIDTH'(WIDTH);
    found     = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && value_in[i]) begin
        count_out = COUNT_WIDTH'(WIDTH - 1 - i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/float_point_add_sub.sv
// Multi-cycle IEEE-754 style adder/subtractor: align, add, normalise, round,
// then hold the result until the consumer acknowledges it.
module float_point_add_sub
  import float_point_add_sub_pkg::*;
#(
  parameter int EXPONENT_WIDTH = DOUBLE_POINT_NUMBER_EXPONENT_WIDTH_IN_BITS,
  parameter int FRACTION_WIDTH = DOUBLE_POINT_NUMBER_FRACTION_WIDTH_IN_BITS
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic                      operantion_mode_in,
  input  logic                      round_mode_in,
  input  logic                      operand_0_valid_in,
  input  logic                      operand_0_sign_in,
  input  logic [EXPONENT_WIDTH-1:0] operand_0_exponent_in,
  input  logic [FRACTION_WIDTH-1:0] operand_0_fraction_in,
  input  logic                      operand_1_valid_in,
  input  logic                      operand_1_sign_in,
  input  logic [EXPONENT_WIDTH-1:0] operand_1_exponent_in,
  input  logic [FRACTION_WIDTH-1:0] operand_1_fraction_in,
  output logic                      issue_ack_out,
  output logic                      product_valid_out,
  output logic                      product_sign_out,
  output logic [EXPONENT_WIDTH-1:0] product_exponent_out,
  output logic [FRACTION_WIDTH-1:0] product_fraction_out,
  output logic                      flag_invalid_out,
  output logic                      flag_overflow_out,
  output logic                      flag_inexact_out,
  input  logic                      issue_ack_in,
  output state_t                    debug_state_out
);

  localparam int E  = EXPONENT_WIDTH;
  localparam int F  = FRACTION_WIDTH;
  localparam int EW = E + 1;
  localparam int AW = F + 4;  // hidden bit, fraction, guard, round, sticky
  localparam int CW = $clog2(AW + 1);
  localparam logic [E-1:0] EXP_ONES     = '1;
  localparam logic [F-1:0] NAN_FRACTION = {1'b1, {(F-1){1'b0}}};

  // Handshake: an operand pair is taken on an edge where issue_ack_out is high,
  // which only happens in IDLE with both valids high; the result is held with
  // product_valid_out high until an edge sees issue_ack_in high.
  state_t state, state_next;

  logic         op0_sign_q, op1_sign_q, mode_q, rm_q;
  logic [E-1:0] op0_exp_q, op1_exp_q;
  logic [F-1:0] op0_frac_q, op1_frac_q;

  logic [AW-1:0] big_q, small_q, mant_q;
  logic [AW:0]   sum_q;
  logic [E:0]    work_exp_q;
  logic          eff_sub_q, res_sign_q, zero_sign_q, nan_q, inf_q, inf_sign_q, invalid_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state <= STATE_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    issue_ack_out = 1'b0;
    case (state)
      STATE_IDLE: begin
        if (operand_0_valid_in && operand_1_valid_in && !reset_in) begin
          issue_ack_out = 1'b1;
          state_next    = STATE_ALIGN;
        end
      end
      STATE_ALIGN:     state_next = STATE_ADD;
      STATE_ADD:       state_next = STATE_NORMALIZE;
      STATE_NORMALIZE: state_next = STATE_ROUND;
      STATE_ROUND:     state_next = STATE_HOLD;
      STATE_HOLD:      if (issue_ack_in) state_next = STATE_IDLE;
      default:         state_next = STATE_IDLE;
    endcase
  end

  assign debug_state_out = state;

  // Alignment: the smaller magnitude shifts right, dropped bits fold into sticky.
  logic [E-1:0]  eff_exp0, eff_exp1, big_exp, small_exp;
  logic [F:0]    sig0, sig1, big_sig, small_sig;
  logic          op0_big, op1_sign_eff, eff_sub, nan0, nan1, inf0, inf1;
  logic [31:0]   shift_amt;
  logic [AW-1:0] small_ext, small_shifted;
  logic          small_lost;

  always_comb begin
    eff_exp0      = (op0_exp_q == '0) ? {{(E-1){1'b0}}, 1'b1} : op0_exp_q;
    eff_exp1      = (op1_exp_q == '0) ? {{(E-1){1'b0}}, 1'b1} : op1_exp_q;
    sig0          = {op0_exp_q != '0, op0_frac_q};
    sig1          = {op1_exp_q != '0, op1_frac_q};
    op0_big       = {eff_exp0, sig0} >= {eff_exp1, sig1};
    big_exp       = op0_big ? eff_exp0 : eff_exp1;
    small_exp     = op0_big ? eff_exp1 : eff_exp0;
    big_sig       = op0_big ? sig0 : sig1;
    small_sig     = op0_big ? sig1 : sig0;
    shift_amt     = 32'(big_exp - small_exp);
    if (shift_amt > 32'(F + 3)) shift_amt = 32'(F + 3);
    small_ext     = {small_sig, 3'b000};
    small_shifted = small_ext >> shift_amt;
    small_lost    = |(small_ext & ~({AW{1'b1}} << shift_amt));
    op1_sign_eff  = op1_sign_q ^ (mode_q == OPERATION_SUB);
    eff_sub       = op0_sign_q ^ op1_sign_eff;
    nan0          = (op0_exp_q == EXP_ONES) && (op0_frac_q != '0);
    nan1          = (op1_exp_q == EXP_ONES) && (op1_frac_q != '0);
    inf0          = (op0_exp_q == EXP_ONES) && (op0_frac_q == '0);
    inf1          = (op1_exp_q == EXP_ONES) && (op1_frac_q == '0);
  end

  logic [CW-1:0] lz_count;
  logic [31:0]   norm_shift, norm_limit;
  logic [AW-1:0] norm_mant;
  logic [E:0]    norm_exp;

  leading_zero_counter #(.WIDTH(AW), .COUNT_WIDTH(CW)) u_lzc (
    .value_in  (sum_q[AW-1:0]),
    .count_out (lz_count)
  );

  // Left shift is limited so the exponent never drops below 1 (denormal floor).
  always_comb begin
    norm_limit = 32'(work_exp_q) - 32'd1;
    norm_shift = (32'(lz_count) < norm_limit) ? 32'(lz_count) : norm_limit;
    if (sum_q[AW]) begin
      norm_mant = {sum_q[AW:2], sum_q[1] | sum_q[0]};
      norm_exp  = work_exp_q + 1'b1;
    end else begin
      norm_mant = sum_q[AW-1:0] << norm_shift;
      norm_exp  = work_exp_q - EW'(norm_shift);
    end
  end

  logic         round_up, inexact_raw;
  logic [F+1:0] rounded;
  logic [F:0]   final_sig;
  logic [E:0]   final_exp;
  logic         nxt_sign, nxt_invalid, nxt_overflow, nxt_inexact;
  logic [E-1:0] nxt_exp;
  logic [F-1:0] nxt_frac;

  always_comb begin
    inexact_raw = |mant_q[2:0];
    round_up    = (rm_q != ROUND_MODE_CHOP) & mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rounded     = {1'b0, mant_q[AW-1:3]} + {{(F+1){1'b0}}, round_up};
    if (rounded[F+1]) begin
      final_sig = rounded[F+1:1];
      final_exp = work_exp_q + 1'b1;
    end else begin
      final_sig = rounded[F:0];
      final_exp = work_exp_q;
    end
    nxt_sign     = res_sign_q;
    nxt_exp      = final_sig[F] ? final_exp[E-1:0] : '0;
    nxt_frac     = final_sig[F-1:0];
    nxt_invalid  = 1'b0;
    nxt_overflow = 1'b0;
    nxt_inexact  = inexact_raw;
    if (nan_q) begin
      nxt_sign    = 1'b0;
      nxt_exp     = EXP_ONES;
      nxt_frac    = NAN_FRACTION;
      nxt_invalid = invalid_q;
      nxt_inexact = 1'b0;
    end else if (inf_q) begin
      nxt_sign    = inf_sign_q;
      nxt_exp     = EXP_ONES;
      nxt_frac    = '0;
      nxt_inexact = 1'b0;
    end else if (final_sig == '0) begin
      nxt_sign = zero_sign_q;
      nxt_exp  = '0;
      nxt_frac = '0;
    end else if (final_exp >= {1'b0, EXP_ONES}) begin
      nxt_overflow = 1'b1;
      nxt_inexact  = 1'b1;
      nxt_exp      = (rm_q == ROUND_MODE_RNE) ? EXP_ONES : EXP_ONES - 1'b1;
      nxt_frac     = (rm_q == ROUND_MODE_RNE) ? '0 : '1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      {op0_sign_q, op1_sign_q, mode_q, rm_q} <= '0;
      {op0_exp_q, op1_exp_q, op0_frac_q, op1_frac_q} <= '0;
      {big_q, small_q, mant_q, sum_q, work_exp_q} <= '0;
      {eff_sub_q, res_sign_q, zero_sign_q, nan_q, inf_q, inf_sign_q, invalid_q} <= '0;
      product_valid_out    <= 1'b0;
      product_sign_out     <= 1'b0;
      product_exponent_out <= '0;
      product_fraction_out <= '0;
      flag_invalid_out     <= 1'b0;
      flag_overflow_out    <= 1'b0;
      flag_inexact_out     <= 1'b0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (issue_ack_out) begin
            op0_sign_q <= operand_0_sign_in;
            op0_exp_q  <= operand_0_exponent_in;
            op0_frac_q <= operand_0_fraction_in;
            op1_sign_q <= operand_1_sign_in;
            op1_exp_q  <= operand_1_exponent_in;
            op1_frac_q <= operand_1_fraction_in;
            mode_q     <= operantion_mode_in;
            rm_q       <= round_mode_in;
          end
        end
        STATE_ALIGN: begin
          big_q       <= {big_sig, 3'b000};
          small_q     <= {small_shifted[AW-1:1], small_shifted[0] | small_lost};
          work_exp_q  <= {1'b0, big_exp};
          eff_sub_q   <= eff_sub;
          res_sign_q  <= op0_big ? op0_sign_q : op1_sign_eff;
          zero_sign_q <= op0_sign_q & op1_sign_eff;
          nan_q       <= nan0 | nan1 | (inf0 & inf1 & eff_sub);
          invalid_q   <= inf0 & inf1 & eff_sub;
          inf_q       <= inf0 | inf1;
          inf_sign_q  <= inf0 ? op0_sign_q : op1_sign_eff;
        end
        STATE_ADD: begin
          sum_q <= eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q}) : ({1'b0, big_q} + {1'b0, small_q});
        end
        STATE_NORMALIZE: begin
          mant_q     <= norm_mant;
          work_exp_q <= norm_exp;
        end
        STATE_ROUND: begin
          product_valid_out    <= 1'b1;
          product_sign_out     <= nxt_sign;
          product_exponent_out <= nxt_exp;
          product_fraction_out <= nxt_frac;
          flag_invalid_out     <= nxt_invalid;
          flag_overflow_out    <= nxt_overflow;
          flag_inexact_out     <= nxt_inexact;
        end
        STATE_HOLD: begin
          if (issue_ack_in) product_valid_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_point_add_sub.sv
// Bench for float_point_add_sub (double precision): directed plan cases plus
// randomized operands checked against an exact-arithmetic reference model.
module tb_float_point_add_sub;
  import float_point_add_sub_pkg::*;

  localparam int E  = 11;
  localparam int F  = 52;
  localparam int RW = 1 + E + F + 3;
  localparam logic [F-1:0] NAN_F = 52'h8000000000000;

  logic clk_in, reset_in;
  logic d_mode, d_rm, d_v0, d_v1, d_s0, d_s1, ack_in;
  logic [E-1:0] d_e0, d_e1;
  logic [F-1:0] d_f0, d_f1;
  logic issue_ack_out, product_valid_out, p_sign, fl_inv, fl_ovf, fl_inx;
  logic [E-1:0] p_exp;
  logic [F-1:0] p_frac;
  state_t dbg_state;
  logic [RW-1:0] got_v;

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW-1:0] exp_q[$];

  float_point_add_sub #(.EXPONENT_WIDTH(E), .FRACTION_WIDTH(F)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .operantion_mode_in(d_mode), .round_mode_in(d_rm),
    .operand_0_valid_in(d_v0), .operand_0_sign_in(d_s0),
    .operand_0_exponent_in(d_e0), .operand_0_fraction_in(d_f0),
    .operand_1_valid_in(d_v1), .operand_1_sign_in(d_s1),
    .operand_1_exponent_in(d_e1), .operand_1_fraction_in(d_f1),
    .issue_ack_out(issue_ack_out), .product_valid_out(product_valid_out),
    .product_sign_out(p_sign), .product_exponent_out(p_exp),
    .product_fraction_out(p_frac), .flag_invalid_out(fl_inv),
    .flag_overflow_out(fl_ovf), .flag_inexact_out(fl_inx),
    .issue_ack_in(ack_in), .debug_state_out(dbg_state)
  );

  assign got_v = {p_sign, p_exp, p_frac, fl_inv, fl_ovf, fl_inx};

  // clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Exact value arithmetic on scaled integers, then IEEE rounding of the true result.
  function automatic logic [RW-1:0] ref_model(input logic s0, input logic [E-1:0] e0,
      input logic [F-1:0] f0, input logic s1, input logic [E-1:0] e1,
      input logic [F-1:0] f1, input logic sub, input logic rne);
    logic sb, sign, inexact, nan0, nan1, inf0, inf1;
    logic [255:0] a, b, mag, kept, rem, half, one;
    int ea, eb, m, p, te, sh;
    sb   = s1 ^ sub;
    nan0 = (e0 == '1) && (f0 != '0);
    nan1 = (e1 == '1) && (f1 != '0);
    inf0 = (e0 == '1) && (f0 == '0);
    inf1 = (e1 == '1) && (f1 == '0);
    if (nan0 || nan1) return {1'b0, {E{1'b1}}, NAN_F, 3'b000};
    if (inf0 && inf1) return (s0 != sb) ? {1'b0, {E{1'b1}}, NAN_F, 3'b100}
                                        : {s0, {E{1'b1}}, {F{1'b0}}, 3'b000};
    if (inf0) return {s0, {E{1'b1}}, {F{1'b0}}, 3'b000};
    if (inf1) return {sb, {E{1'b1}}, {F{1'b0}}, 3'b000};
    a = 256'(f0); if (e0 != '0) a[F] = 1'b1;
    b = 256'(f1); if (e1 != '0) b[F] = 1'b1;
    ea = (e0 == '0) ? 1 : int'(e0);
    eb = (e1 == '0) ? 1 : int'(e1);
    m  = (ea < eb) ? ea : eb;
    a  = a << (ea - m);
    b  = b << (eb - m);
    if (s0 == sb) begin mag = a + b; sign = s0; end
    else if (a >= b) begin mag = a - b; sign = s0; end
    else begin mag = b - a; sign = sb; end
    if (mag == '0) return {s0 & sb, {E{1'b0}}, {F{1'b0}}, 3'b000};
    p = 0;
    for (int i = 0; i < 256; i++) if (mag[i]) p = i;
    te  = m + p - F;
    if (te < 1) te = 1;
    sh  = te - m;
    one = 256'd1;
    if (sh > 0) begin
      kept = mag >> sh;
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
    end else begin
      kept = mag << (-sh);
      rem  = '0;
      half = '0;
    end
    inexact = (rem != '0);
    if (rne && sh > 0 && (rem > half || (rem == half && kept[0]))) kept = kept + one;
    if (kept[F+1]) begin kept = kept >> 1; te++; end
    if (te >= 2047) begin
      if (rne) return {sign, {E{1'b1}}, {F{1'b0}}, 3'b011};
      return {sign, 11'h7FE, {F{1'b1}}, 3'b011};
    end
    return {sign, kept[F] ? E'(te) : {E{1'b0}}, kept[F-1:0], 2'b00, inexact};
  endfunction

  // driver: one transaction, result check, optional hold phase, then release
  task automatic run_txn(input logic a_s, input logic [E-1:0] a_e, input logic [F-1:0] a_f,
      input logic b_s, input logic [E-1:0] b_e, input logic [F-1:0] b_f,
      input logic sub, input logic rne, input int hold, input logic busy,
      input logic use_lit, input logic [RW-1:0] lit, input string tag);
    logic [RW-1:0] exp_v;
    int lat;
    exp_q.push_back(ref_model(a_s, a_e, a_f, b_s, b_e, b_f, sub, rne));
    @(negedge clk_in);
    d_s0 = a_s; d_e0 = a_e; d_f0 = a_f;
    d_s1 = b_s; d_e1 = b_e; d_f1 = b_f;
    d_mode = sub; d_rm = rne; d_v0 = 1'b1; d_v1 = 1'b1;
    #1 check({tag, ":accept"}, issue_ack_out, 1'b1);
    @(posedge clk_in); #1;
    d_v0 = 1'b0; d_v1 = 1'b0;
    lat = 0;
    while (!product_valid_out && lat < 20) begin
      @(posedge clk_in); #1;
      lat++;
    end
    check({tag, ":latency"}, lat, 4);
    exp_v = exp_q.pop_front();
    check({tag, ":result"}, got_v, exp_v);
    if (use_lit) check({tag, ":plan"}, got_v, lit);
    if (busy) begin
      d_v0 = 1'b1; d_v1 = 1'b1;
      d_e0 = E'($urandom); d_e1 = E'($urandom); d_f0 = F'($urandom); d_f1 = F'($urandom);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_in); #1;
      check({tag, ":hold"}, {product_valid_out, issue_ack_out, got_v}, {1'b1, 1'b0, exp_v});
    end
    @(negedge clk_in);
    ack_in = 1'b1;
    #1 check({tag, ":release_no_ack"}, issue_ack_out, 1'b0);
    @(posedge clk_in); #1;
    ack_in = 1'b0;
    check({tag, ":drop"}, product_valid_out, 1'b0);
    if (busy) check({tag, ":reaccept_ready"}, issue_ack_out, 1'b1);
  endtask

  initial begin
    logic [63:0] r0, r1;
    logic [F-1:0] f0, f1;
    int e0i, e1i, sel;
    reset_in = 1'b1; ack_in = 1'b0;
    d_mode = 1'b0; d_rm = 1'b0; d_v0 = 1'b0; d_v1 = 1'b0;
    d_s0 = 1'b0; d_s1 = 1'b0; d_e0 = '0; d_e1 = '0; d_f0 = '0; d_f1 = '0;
    repeat (3) @(posedge clk_in);
    #1 check("reset_outputs", {product_valid_out, issue_ack_out, got_v}, '0);
    check("reset_state", dbg_state, STATE_IDLE);
    @(negedge clk_in); reset_in = 1'b0;

    run_txn(0, 11'h3FF, 0, 0, 11'h3FF, 0, 0, 1, 0, 0, 1, {1'b0, 11'h400, 52'h0, 3'b000}, "one_plus_one");
    run_txn(0, 11'h3FF, 0, 0, 11'h3FF, 0, 1, 1, 0, 0, 1, {1'b0, 11'h000, 52'h0, 3'b000}, "one_minus_one_rne");
    run_txn(0, 11'h3FF, 0, 0, 11'h3FF, 0, 1, 0, 0, 0, 1, {1'b0, 11'h000, 52'h0, 3'b000}, "one_minus_one_chop");
    run_txn(1, 11'h000, 0, 1, 11'h000, 0, 0, 1, 0, 0, 1, {1'b1, 11'h000, 52'h0, 3'b000}, "negzero_sum");
    run_txn(0, 11'h3FF, 0, 0, 11'h3CA, 0, 0, 1, 0, 0, 1, {1'b0, 11'h3FF, 52'h0, 3'b001}, "tie_even_rne");
    run_txn(0, 11'h3FF, 1, 0, 11'h3CA, 0, 0, 1, 0, 0, 1, {1'b0, 11'h3FF, 52'h2, 3'b001}, "tie_odd_rne");
    run_txn(0, 11'h3FF, 0, 0, 11'h3CA, 0, 0, 0, 0, 0, 1, {1'b0, 11'h3FF, 52'h0, 3'b001}, "tie_even_chop");
    run_txn(0, 11'h3FF, 1, 0, 11'h3CA, 0, 0, 0, 0, 0, 1, {1'b0, 11'h3FF, 52'h1, 3'b001}, "tie_odd_chop");
    run_txn(0, 11'h7FF, 0, 0, 11'h7FF, 0, 1, 1, 0, 0, 1, {1'b0, 11'h7FF, NAN_F, 3'b100}, "inf_minus_inf");
    run_txn(0, 11'h7FF, 52'h1234, 0, 11'h3FF, 0, 0, 1, 0, 0, 1, {1'b0, 11'h7FF, NAN_F, 3'b000}, "nan_plus_one");
    run_txn(0, 11'h7FE, '1, 0, 11'h7FE, '1, 0, 1, 0, 0, 1, {1'b0, 11'h7FF, 52'h0, 3'b011}, "max_plus_max_rne");
    run_txn(0, 11'h7FE, '1, 0, 11'h7FE, '1, 0, 0, 0, 0, 1, {1'b0, 11'h7FE, {F{1'b1}}, 3'b011}, "max_plus_max_chop");

    // held result with valids pending, then accept right after release
    run_txn(1, 11'h400, 52'h8000000000000, 0, 11'h3FE, 0, 0, 1, 10, 1, 0, '0, "hold_stable");
    run_txn(0, 11'h401, 52'h0, 1, 11'h3FF, 0, 1, 1, 0, 0, 0, '0, "after_hold");

    // reset during NORMALIZE discards the transaction
    @(negedge clk_in);
    d_s0 = 0; d_e0 = 11'h3FF; d_f0 = 0; d_s1 = 0; d_e1 = 11'h3FF; d_f1 = 0;
    d_mode = 0; d_rm = 1; d_v0 = 1; d_v1 = 1;
    @(posedge clk_in); #1;
    d_v0 = 0; d_v1 = 0;
    @(posedge clk_in); @(posedge clk_in); #1;
    check("rst_mid:in_normalize", dbg_state, STATE_NORMALIZE);
    #2 reset_in = 1'b1;
    #1 check("rst_mid:outputs_zero", {product_valid_out, issue_ack_out, got_v}, '0);
    check("rst_mid:state_idle", dbg_state, STATE_IDLE);
    @(negedge clk_in); reset_in = 1'b0;
    repeat (4) begin
      @(posedge clk_in); #1;
      check("rst_mid:no_stale", product_valid_out, 1'b0);
    end
    run_txn(0, 11'h3FF, 0, 0, 11'h400, 0, 0, 1, 0, 0, 1, {1'b0, 11'h400, 52'h8000000000000, 3'b000}, "after_reset");

    // randomized operands
    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 15));
      r0 = {$urandom, $urandom}; r1 = {$urandom, $urandom};
      f0 = r0[F-1:0]; f1 = r1[F-1:0];
      e0i = int'($urandom_range(0, 2046));
      e1i = e0i + int'($urandom_range(0, 140)) - 70;
      if (sel == 0) e0i = 2047;
      if (sel == 1) e1i = 2047;
      if (sel == 2) begin e1i = e0i; f1 = f0; end
      if (sel == 3) f0 = '0;
      if (sel == 4) begin e0i = 0; e1i = int'($urandom_range(0, 3)); end
      if (sel == 5) e1i = e0i - int'($urandom_range(54, 180));
      if (sel == 6) e1i = e0i + int'($urandom_range(54, 180));
      if (sel == 7) begin e0i = int'($urandom_range(2040, 2046)); e1i = e0i; end
      if (e1i < 0) e1i = 0;
      if (e1i > 2047) e1i = 2046;
      run_txn(1'($urandom), E'(e0i), f0, 1'($urandom), E'(e1i), f1,
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0, 0, '0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
